// File: rtl/instr_prefetch_buffer.sv
// Sequential instruction prefetcher: one outstanding bus fetch at a time, a small
// registered FIFO toward the core, and redirect handling that flushes stale fetches.
module instr_prefetch_buffer #(
  parameter int          DEPTH     = 2,
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect,
  input  logic [31:0] redirect_addr,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_rdata,
  output logic [31:0] instr_addr,
  output logic        instr_bus_req,
  output logic [31:0] instr_bus_addr,
  input  logic        instr_bus_gnt,
  input  logic        instr_bus_rvalid,
  input  logic [31:0] instr_bus_rdata
);

  localparam int            PW   = $clog2(DEPTH);
  localparam int            CW   = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          active_q;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wait_addr_q, wait_addr_d;
  logic          discard_q, discard_d;
  logic          flush_q, flush_d;
  logic [31:0]   redir_pc_q, redir_pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;

  logic [31:0]   data_mem [DEPTH];
  logic [31:0]   addr_mem [DEPTH];

  logic [31:0]   redir_target;
  logic          gnt_fire;
  logic          rsp_fire;
  logic          push;
  logic          pop;
  logic [1:0]    unused_addr_bits;

  assign redir_target     = {redirect_addr[31:2], 2'b00};
  assign unused_addr_bits = redirect_addr[1:0];

  // The request only appears once the first clock edge after reset release has passed.
  assign instr_bus_req  = active_q && (state_q == S_REQ);
  assign instr_bus_addr = addr_q;
  assign gnt_fire       = instr_bus_req && instr_bus_gnt;
  assign rsp_fire       = (state_q == S_WAIT) && instr_bus_rvalid;
  assign push           = rsp_fire && !discard_q && !redirect;
  assign pop            = instr_valid && instr_ready && !redirect;

  assign instr_valid = (count_q != '0);
  assign instr_rdata = data_mem[rd_ptr_q];
  assign instr_addr  = addr_mem[rd_ptr_q];

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wait_addr_d = wait_addr_q;
    discard_d   = discard_q;
    flush_d     = flush_q;
    redir_pc_d  = redir_pc_q;
    count_d     = count_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;

    if (redirect) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      count_d = count_q + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    end

    unique case (state_q)
      S_IDLE: begin
        if (redirect) addr_d = redir_target;
        if (count_d < FULL) state_d = S_REQ;
      end
      S_REQ: begin
        if (gnt_fire) begin
          state_d     = S_WAIT;
          wait_addr_d = addr_q;
          // A grant racing a redirect, or one already marked stale, belongs to the old stream.
          discard_d   = flush_q || redirect;
          flush_d     = 1'b0;
          if (redirect)     addr_d = redir_target;
          else if (flush_q) addr_d = redir_pc_q;
          else              addr_d = addr_q + 32'd4;
        end else if (redirect) begin
          if (active_q) begin
            flush_d    = 1'b1;
            redir_pc_d = redir_target;
          end else begin
            addr_d = redir_target;
          end
        end
      end
      S_WAIT: begin
        if (rsp_fire) begin
          discard_d = 1'b0;
          state_d   = (count_d < FULL) ? S_REQ : S_IDLE;
          if (redirect) addr_d = redir_target;
        end else if (redirect) begin
          discard_d = 1'b1;
          addr_d    = redir_target;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_REQ;
      active_q    <= 1'b0;
      addr_q      <= BOOT_ADDR;
      wait_addr_q <= BOOT_ADDR;
      discard_q   <= 1'b0;
      flush_q     <= 1'b0;
      redir_pc_q  <= BOOT_ADDR;
      count_q     <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      active_q    <= 1'b1;
      addr_q      <= addr_d;
      wait_addr_q <= wait_addr_d;
      discard_q   <= discard_d;
      flush_q     <= flush_d;
      redir_pc_q  <= redir_pc_d;
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr_q] <= instr_bus_rdata;
      addr_mem[wr_ptr_q] <= wait_addr_q;
    end
  end

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// Bench for instr_prefetch_buffer: randomized bus/core stimulus checked every cycle
// against a queue-based model, plus directed scenarios with literal expectations.
module tb_instr_prefetch_buffer;

  localparam int          DEPTH     = 2;
  localparam logic [31:0] BOOT_ADDR = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_addr = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr_rdata;
  logic [31:0] instr_addr;
  logic        instr_bus_req;
  logic [31:0] instr_bus_addr;
  logic        instr_bus_gnt = 1'b0;
  logic        instr_bus_rvalid = 1'b0;
  logic [31:0] instr_bus_rdata = '0;

  instr_prefetch_buffer #(.DEPTH(DEPTH), .BOOT_ADDR(BOOT_ADDR)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .redirect         (redirect),
    .redirect_addr    (redirect_addr),
    .instr_valid      (instr_valid),
    .instr_ready      (instr_ready),
    .instr_rdata      (instr_rdata),
    .instr_addr       (instr_addr),
    .instr_bus_req    (instr_bus_req),
    .instr_bus_addr   (instr_bus_addr),
    .instr_bus_gnt    (instr_bus_gnt),
    .instr_bus_rvalid (instr_bus_rvalid),
    .instr_bus_rdata  (instr_bus_rdata)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Reference model: buffered words, next fetch address, and the outstanding fetch.
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } ent_t;
  ent_t        mq[$];
  logic [31:0] m_pc;
  bit          m_started;
  bit          m_inflight;
  logic [31:0] m_if_addr;
  bit          m_if_drop;
  bit          m_kill;
  logic [31:0] m_kill_tgt;

  // Bus responder and stimulus knobs.
  bit          pend = 0;
  int          pend_lat = 0;
  logic [31:0] pend_data = '0;
  int unsigned gnt_pct = 100, ready_pct = 100, redir_pct = 0, spur_pct = 0;
  int unsigned lat_min = 1, lat_max = 1;
  bit          force_redir = 0;
  logic [31:0] force_addr = '0;
  bit          arm_combo = 0;
  logic [31:0] combo_addr = '0;
  bit          chk_combo_next = 0;
  bit          verbose = 1;
  int          release_cyc = 0;
  int          first_valid_at = -1;

  logic [31:0] grant_log [256];
  logic [31:0] deliv_log [256];
  int          n_grant = 0;
  int          n_deliv = 0;

  function automatic logic [31:0] glog(input int i);
    return (i < n_grant) ? grant_log[i] : 32'hxxxx_xxxx;
  endfunction

  function automatic logic [31:0] dlog(input int i);
    return (i < n_deliv) ? deliv_log[i] : 32'hxxxx_xxxx;
  endfunction

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic bit m_req();
    return m_started && !m_inflight && (mq.size() < DEPTH);
  endfunction

  task automatic m_reset();
    mq.delete();
    m_pc       = BOOT_ADDR;
    m_started  = 0;
    m_inflight = 0;
    m_if_addr  = '0;
    m_if_drop  = 0;
    m_kill     = 0;
    m_kill_tgt = '0;
  endtask

  task automatic m_step(input bit rd, input logic [31:0] ra, input bit rdy,
                        input bit g, input bit rv, input logic [31:0] rdat);
    bit          req_now, was_inflight, granted, responded;
    logic [31:0] tgt;
    ent_t        e;
    req_now      = m_req();
    was_inflight = m_inflight;
    granted      = req_now && g;
    responded    = m_inflight && rv;
    tgt          = ra & 32'hFFFF_FFFC;

    if (rd) mq.delete();
    else begin
      if (mq.size() != 0 && rdy) void'(mq.pop_front());
      if (responded && !m_if_drop) begin
        e.a = m_if_addr;
        e.d = rdat;
        mq.push_back(e);
      end
    end

    if (granted) begin
      m_inflight = 1;
      m_if_addr  = m_pc;
      m_if_drop  = m_kill || rd;
      m_pc       = rd ? tgt : (m_kill ? m_kill_tgt : m_pc + 32'd4);
      m_kill     = 0;
    end else if (req_now && rd) begin
      m_kill     = 1;
      m_kill_tgt = tgt;
    end

    if (was_inflight) begin
      if (responded) begin
        m_inflight = 0;
        m_if_drop  = 0;
        if (rd) m_pc = tgt;
      end else if (rd) begin
        m_if_drop = 1;
        m_pc      = tgt;
      end
    end else if (!req_now && rd) begin
      m_pc = tgt;
    end
    m_started = 1;
  endtask

  task automatic step(input bit release_rst);
    bit          rd, rv, g, rdy, forced;
    logic [31:0] ra, rdat;
    @(negedge clk);
    cyc++;
    if (!rst_n) begin
      chk32("reset_valid", {31'b0, instr_valid}, 32'd0);
      chk32("reset_req", {31'b0, instr_bus_req}, 32'd0);
      chk32("reset_bus_addr", instr_bus_addr, BOOT_ADDR);
    end else begin
      chk32("valid", {31'b0, instr_valid}, {31'b0, mq.size() != 0});
      if (mq.size() != 0) begin
        chk32("instr_addr", instr_addr, mq[0].a);
        chk32("instr_rdata", instr_rdata, mq[0].d);
      end
      chk32("bus_req", {31'b0, instr_bus_req}, {31'b0, m_req()});
      if (m_req()) chk32("bus_addr", instr_bus_addr, m_pc);
    end
    if (chk_combo_next) begin
      chk32("combo_valid_next", {31'b0, instr_valid}, 32'd0);
      chk_combo_next = 0;
    end
    if (rst_n && instr_valid && first_valid_at < 0) first_valid_at = cyc - release_cyc;
    if (release_rst) begin
      rst_n       = 1'b1;
      release_cyc = cyc;
    end

    rdy = ($urandom_range(99) < ready_pct);
    g   = ($urandom_range(99) < gnt_pct);
    ra  = $urandom;
    if ($urandom_range(7) == 0) ra = 32'hFFFF_FFF0 | ($urandom & 32'hF);
    rd     = ($urandom_range(99) < redir_pct);
    forced = 0;
    if (force_redir) begin
      rd = 1; ra = force_addr; force_redir = 0; forced = 1;
    end
    rv   = 0;
    rdat = $urandom;
    if (pend) begin
      if (pend_lat <= 1) begin
        rv = 1; rdat = pend_data; pend = 0;
      end else pend_lat--;
    end else if ($urandom_range(99) < spur_pct) rv = 1;
    if (arm_combo && rv && instr_valid && rst_n) begin
      rd = 1; ra = combo_addr; rdy = 1; arm_combo = 0; forced = 1; chk_combo_next = 1;
    end
    if (forced) begin
      n_grant = 0; n_deliv = 0;
      if (verbose) $display("redirect to %h", ra);
    end
    if (rst_n && instr_bus_req && g) begin
      pend      = 1;
      pend_lat  = $urandom_range(lat_max, lat_min);
      pend_data = $urandom;
      if (n_grant < 256) grant_log[n_grant++] = instr_bus_addr;
      if (verbose) $display("grant addr=%h", instr_bus_addr);
    end
    if (rst_n && instr_valid && rdy && !rd) begin
      if (n_deliv < 256) deliv_log[n_deliv++] = instr_addr;
      if (verbose) $display("deliver addr=%h data=%h", instr_addr, instr_rdata);
    end

    redirect         = rd;
    redirect_addr    = ra;
    instr_ready      = rdy;
    instr_bus_gnt    = g;
    instr_bus_rvalid = rv;
    instr_bus_rdata  = rdat;
    if (rst_n) m_step(rd, ra, rdy, g, rv, rdat);
  endtask

  task automatic do_reset(input bit clr_pend);
    #2 rst_n = 1'b0;
    m_reset();
    n_grant = 0;
    n_deliv = 0;
    first_valid_at = -1;
    if (clr_pend) pend = 0;
    step(0);
    step(0);
    step(1);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(0);
  endtask

  task automatic knobs(input int unsigned g, input int unsigned lmin, input int unsigned lmax,
                       input int unsigned r, input int unsigned rd, input int unsigned sp);
    gnt_pct = g; lat_min = lmin; lat_max = lmax; ready_pct = r; redir_pct = rd; spur_pct = sp;
  endtask

  initial begin
    m_reset();

    // Boot: grant immediately, response one cycle later, core always ready.
    knobs(100, 1, 1, 100, 0, 0);
    do_reset(1);
    run(10);
    chk32("boot_grant0", glog(0), 32'h0);
    chk32("boot_grant1", glog(1), 32'h4);
    chk32("boot_grant2", glog(2), 32'h8);
    chk32("boot_deliv0", dlog(0), 32'h0);
    chk32("boot_first_valid_latency", first_valid_at, 32'd3);

    // Backpressure: core stalled, buffer fills and fetching stops.
    knobs(100, 1, 1, 0, 0, 0);
    do_reset(1);
    run(12);
    chk32("bp_req_low", {31'b0, instr_bus_req}, 32'd0);
    chk32("bp_valid", {31'b0, instr_valid}, 32'd1);
    chk32("bp_head_addr", instr_addr, 32'h0);
    chk32("bp_grants", n_grant, 32'd2);
    ready_pct = 100;
    run(12);
    chk32("bp_deliv0", dlog(0), 32'h0);
    chk32("bp_deliv1", dlog(1), 32'h4);
    chk32("bp_resume", glog(2), 32'h8);

    // Redirect while waiting for the response of 0x10.
    knobs(100, 4, 4, 100, 0, 0);
    do_reset(1);
    begin
      bit found = 0;
      for (int i = 0; i < 100 && !found; i++) begin
        step(0);
        if (n_grant > 0 && grant_log[n_grant-1] == 32'h10) found = 1;
      end
      chk32("wait_grant_0x10", {31'b0, found}, 32'd1);
    end
    force_redir = 1; force_addr = 32'h203;
    run(30);
    chk32("rw_grant0", glog(0), 32'h200);
    chk32("rw_deliv0", dlog(0), 32'h200);

    // Redirect while a request is pending without grant.
    knobs(0, 1, 1, 100, 0, 0);
    do_reset(1);
    step(0);
    force_redir = 1; force_addr = 32'h400;
    run(3);
    gnt_pct = 100;
    run(15);
    chk32("rp_grant0_old", glog(0), 32'h0);
    chk32("rp_grant1", glog(1), 32'h400);
    chk32("rp_grant2", glog(2), 32'h404);
    chk32("rp_deliv0", dlog(0), 32'h400);

    // Redirect coinciding with a response and a pop.
    knobs(100, 2, 2, 30, 0, 0);
    do_reset(1);
    arm_combo = 1; combo_addr = 32'h800;
    for (int i = 0; i < 400 && arm_combo; i++) step(0);
    chk32("combo_reached", {31'b0, arm_combo}, 32'd0);
    arm_combo = 0;
    ready_pct = 100;
    run(20);
    chk32("combo_grant0", glog(0), 32'h800);
    chk32("combo_deliv0", dlog(0), 32'h800);

    // Address wrap; low bits of the redirect address are ignored.
    knobs(100, 1, 1, 100, 0, 0);
    force_redir = 1; force_addr = 32'hFFFF_FFFE;
    run(12);
    chk32("wrap_grant0", glog(0), 32'hFFFF_FFFC);
    chk32("wrap_grant1", glog(1), 32'h0000_0000);
    chk32("wrap_deliv0", dlog(0), 32'hFFFF_FFFC);
    chk32("wrap_deliv1", dlog(1), 32'h0000_0000);
    chk32("wrap_deliv2", dlog(2), 32'h0000_0004);

    // Randomized traffic, occasional redirects, stray responses and resets.
    verbose = 0;
    for (int s = 0; s < 20; s++) begin
      knobs($urandom_range(100, 30), 1, $urandom_range(5, 1), $urandom_range(100, 0),
            $urandom_range(8, 0), 5);
      if ($urandom_range(4) == 0) do_reset(0);
      run(150);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
